// File: rtl/fpga_synth_usb_gpx_filter_if.sv
// fpga_synth_usb_gpx_filter_if: Avalon-MM slave bus for the GPX filter register block
interface fpga_synth_usb_gpx_filter_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/fpga_synth_usb_gpx_filter.sv
// fpga_synth_usb_gpx_filter: GPX pin synchroniser and glitch filter with an Avalon-MM edge/IRQ slave
module fpga_synth_usb_gpx_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic gpx_pin,
  fpga_synth_usb_gpx_filter_if.slave bus,
  output logic irq,
  output logic gpx_level
);
  localparam logic [7:0] FLIM = 8'(FILTER_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0] fcnt;
  logic [15:0] event_count;
  logic [31:0] rd_mux;
  logic edge_capture, irq_mask, sync_out, toggle, edge_evt, wr;
  assign sync_out = sync[SYNC_STAGES-1];
  assign toggle = (sync_out != gpx_level) && (fcnt == FLIM);
  // mode 0 qualifies a 0->1 toggle, mode 1 a 1->0 toggle, mode 2 both
  assign edge_evt = toggle && (EDGE_MODE == 2 || ((EDGE_MODE == 1) == gpx_level));
  assign wr = bus.chipselect && !bus.write_n;
  assign irq = edge_capture && irq_mask;
  always_comb
    rd_mux = bus.address == 2'd0 ? {30'd0, sync_out, gpx_level} :
             bus.address == 2'd1 ? {31'd0, irq_mask} :
             bus.address == 2'd2 ? {16'd0, event_count} : {31'd0, edge_capture};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      fcnt <= '0;
      gpx_level <= 1'b0;
      edge_capture <= 1'b0;
      irq_mask <= 1'b0;
      event_count <= '0;
      bus.readdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], gpx_pin};
      fcnt <= (sync_out == gpx_level || toggle) ? 8'd0 : fcnt + 8'd1;
      if (toggle) gpx_level <= !gpx_level;
      if (wr && bus.address == 2'd1) irq_mask <= bus.writedata[0];
      // a new edge beats a simultaneous clear so no event is lost
      edge_capture <= edge_evt || (edge_capture && !(wr && bus.address == 2'd3 && bus.writedata[0]));
      if (wr && bus.address == 2'd2) event_count <= {15'd0, edge_evt};
      else if (edge_evt && event_count != 16'hFFFF) event_count <= event_count + 16'd1;
      bus.readdata <= rd_mux;
    end
endmodule

// File: tb/tb_fpga_synth_usb_gpx_filter.sv
// tb_fpga_synth_usb_gpx_filter: vector table plus hand sequences, readback checked through a scoreboard queue
module tb_fpga_synth_usb_gpx_filter;
  typedef struct {
    logic        pin;
    int          waits;
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] e0, e1, e2;
  } vec_t;
  typedef struct {
    string       nm;
    int          d;
    logic [31:0] exp;
  } sb_t;
  logic clk, reset_n, gpx_pin, pin2;
  logic [1:0] address;
  logic chipselect, write_n;
  logic [31:0] writedata;
  logic lvl0, lvl1, lvl2, irq0, irq1, irq2;
  int n_chk = 0;
  int n_fail = 0;
  sb_t q[$];
  vec_t vt[$];
  fpga_synth_usb_gpx_filter_if b0();
  fpga_synth_usb_gpx_filter_if b1();
  fpga_synth_usb_gpx_filter_if b2();
  assign b0.address = address;
  assign b0.chipselect = chipselect;
  assign b0.write_n = write_n;
  assign b0.writedata = writedata;
  assign b1.address = address;
  assign b1.chipselect = chipselect;
  assign b1.write_n = write_n;
  assign b1.writedata = writedata;
  assign b2.address = address;
  assign b2.chipselect = chipselect;
  assign b2.write_n = write_n;
  assign b2.writedata = writedata;
  fpga_synth_usb_gpx_filter d0 (.clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .bus(b0), .irq(irq0), .gpx_level(lvl0));
  fpga_synth_usb_gpx_filter #(.EDGE_MODE(1)) d1 (.clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .bus(b1), .irq(irq1), .gpx_level(lvl1));
  fpga_synth_usb_gpx_filter #(.FILTER_CYCLES(1), .EDGE_MODE(2)) d2 (.clk(clk), .reset_n(reset_n), .gpx_pin(pin2), .bus(b2), .irq(irq2), .gpx_level(lvl2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] rdat(int d);
    return d == 0 ? b0.readdata : d == 1 ? b1.readdata : b2.readdata;
  endfunction
  function automatic vec_t mk(logic p, int w, logic cs, logic wr, logic [1:0] a, logic [31:0] wd,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.pin = p; v.waits = w; v.cs = cs; v.wr = wr; v.addr = a; v.wdata = wd;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, rdat(e.d), e.exp);
    end
  endtask
  task automatic set_pin(input logic p);
    gpx_pin = p;
    pin2 = p;
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd0(input logic [1:0] a, input logic [31:0] e, input string nm);
    address = a;
    q.push_back('{nm: nm, d: 0, exp: e});
    tick();
  endtask
  task automatic rise_with_write(input logic [1:0] a, input logic [31:0] d);
    set_pin(1'b1);
    repeat (5) tick();
    wr_reg(a, d);
  endtask
  initial begin
    logic [5:0] h0, h2;
    logic [7:0] hi, hr;
    logic [13:0] hp;
    reset_n = 1'b0; set_pin(1'b1);
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) tick();
    chk("rst_level", {31'd0, lvl0}, 32'd0);
    chk("rst_irq", {31'd0, irq0}, 32'd0);
    chk("rst_readdata", b0.readdata, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      h0[i] = lvl0;
      h2[i] = lvl2;
    end
    chk("rst_rise_d0", {26'd0, h0}, {26'd0, 6'b100000});
    chk("rst_rise_f1", {26'd0, h2}, {26'd0, 6'b111100});
    chk("rst_irq_masked", {31'd0, irq0}, 32'd0);
    address = 2'd2;
    q.push_back('{nm: "rst_cnt_d0", d: 0, exp: 32'd1});
    q.push_back('{nm: "rst_cnt_d1", d: 1, exp: 32'd0});
    q.push_back('{nm: "rst_cnt_d2", d: 2, exp: 32'd1});
    tick();
    vt.push_back(mk(1, 0, 1, 1, 2'd3, 32'd1, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 1, 2'd2, 32'd0, 1, 0, 1));
    vt.push_back(mk(0, 2, 0, 0, 2'd0, 32'd0, 1, 1, 1));
    vt.push_back(mk(0, 8, 1, 0, 2'd3, 32'd0, 0, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 2'd2, 32'd0, 0, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 2'd3, 32'd1, 0, 1, 1));
    vt.push_back(mk(1, 10, 1, 0, 2'd3, 32'd0, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 2'd2, 32'd0, 1, 1, 2));
    vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'd0, 3, 3, 3));
    vt.push_back(mk(1, 0, 1, 1, 2'd1, 32'hFFFF_FFFF, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 0, 2'd1, 32'd0, 1, 1, 1));
    vt.push_back(mk(1, 0, 1, 1, 2'd3, 32'd0, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 2'd3, 32'd0, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 1, 2'd1, 32'd0, 1, 1, 1));
    vt.push_back(mk(1, 0, 1, 0, 2'd1, 32'd0, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 1, 2'd0, 32'hFFFF_FFFF, 3, 3, 3));
    vt.push_back(mk(1, 0, 0, 0, 2'd0, 32'd0, 3, 3, 3));
    vt.push_back(mk(1, 0, 1, 1, 2'd3, 32'd1, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 1, 2'd2, 32'd0, 1, 1, 2));
    vt.push_back(mk(1, 0, 1, 0, 2'd2, 32'd0, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 0, 2'd3, 32'd0, 0, 0, 0));
    foreach (vt[i]) begin
      set_pin(vt[i].pin);
      repeat (vt[i].waits) tick();
      address = vt[i].addr; chipselect = vt[i].cs; write_n = !vt[i].wr; writedata = vt[i].wdata;
      q.push_back('{nm: $sformatf("vec%0d_d0", i), d: 0, exp: vt[i].e0});
      q.push_back('{nm: $sformatf("vec%0d_d1", i), d: 1, exp: vt[i].e1});
      q.push_back('{nm: $sformatf("vec%0d_d2", i), d: 2, exp: vt[i].e2});
      tick();
      chipselect = 1'b0; write_n = 1'b1;
    end
    // glitch rejection: 3-cycle pulse filtered out, 4-cycle pulse passes
    for (int i = 0; i < 14; i++) begin
      set_pin(i < 3 ? 1'b0 : 1'b0);
    end
    set_pin(1'b0);
    repeat (10) tick();
    wr_reg(2'd3, 32'd1);
    wr_reg(2'd2, 32'd0);
    set_pin(1'b1);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 2) set_pin(1'b0);
      hp[i] = lvl0;
    end
    chk("glitch3", {18'd0, hp}, 32'd0);
    set_pin(1'b1);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 3) set_pin(1'b0);
      hp[i] = lvl0;
    end
    chk("pulse4", {18'd0, hp}, {18'd0, 14'h01E0});
    rd0(2'd3, 32'd1, "pulse4_cap");
    rd0(2'd2, 32'd1, "pulse4_cnt");
    // interrupt flow
    wr_reg(2'd3, 32'd1);
    wr_reg(2'd1, 32'd1);
    set_pin(1'b0);
    repeat (10) tick();
    chk("irq_no_fall", {31'd0, irq0}, 32'd0);
    address = 2'd3;
    set_pin(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      hi[i] = irq0;
      hr[i] = b0.readdata[0];
    end
    chk("irq_rise", {24'd0, hi}, 32'h0000_00E0);
    chk("cap_readback", {24'd0, hr}, 32'h0000_00C0);
    wr_reg(2'd3, 32'd0);
    chk("irq_w0_keep", {31'd0, irq0}, 32'd1);
    wr_reg(2'd1, 32'd0);
    chk("irq_mask_off", {31'd0, irq0}, 32'd0);
    wr_reg(2'd1, 32'd1);
    chk("irq_mask_on", {31'd0, irq0}, 32'd1);
    wr_reg(2'd3, 32'd1);
    chk("irq_w1c", {31'd0, irq0}, 32'd0);
    // clear writes landing on the edge_evt cycle
    set_pin(1'b0);
    repeat (10) tick();
    wr_reg(2'd3, 32'd1);
    wr_reg(2'd2, 32'd0);
    rise_with_write(2'd3, 32'd1);
    rd0(2'd3, 32'd1, "simul_cap_kept");
    rd0(2'd2, 32'd1, "simul_cnt");
    set_pin(1'b0);
    repeat (10) tick();
    rise_with_write(2'd2, 32'd0);
    rd0(2'd2, 32'd1, "simul_cnt_load1");
    rd0(2'd3, 32'd1, "simul_cap2");
    // saturation on the single-sample, both-edge instance
    wr_reg(2'd2, 32'd0);
    for (int i = 0; i < 65600; i++) begin
      pin2 = !pin2;
      tick();
    end
    repeat (5) tick();
    address = 2'd2;
    q.push_back('{nm: "sat_d0", d: 0, exp: 32'd0});
    q.push_back('{nm: "sat_d1", d: 1, exp: 32'd0});
    q.push_back('{nm: "sat_d2", d: 2, exp: 32'h0000_FFFF});
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
